// File: rtl/led_writer_pkg.sv
// led_writer_pkg: register addresses and CTRL bit positions shared by the LED writer.
`default_nettype none

package led_writer_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_PHASE = 1;

endpackage

`default_nettype wire

// File: rtl/led_writer_blink_timer.sv
// blink_timer: half-period counter that toggles a blink phase every `period` enabled cycles.
`default_nettype none

module blink_timer
  import led_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period,
  input  logic        enable,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A restart wins over everything, including a wrap in the same cycle.
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (enable) begin
      if (period == 32'd0) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (cnt_q == period - 32'd1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/led_writer.sv
// led_writer: Avalon-MM slave driving LEDs with a data register, per-LED blink mask and blink timer.
`default_nettype none

module led_writer
  import led_writer_pkg::*;
#(
  parameter int          LED_W          = 10,
  parameter int unsigned DEFAULT_PERIOD = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led
);

  logic [LED_W-1:0] data_q, data_d;
  logic [LED_W-1:0] mask_q, mask_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             en_q, en_d;
  logic             phase;
  logic             wr_en, rd_en, restart;
  logic [31:0]      rd_word;

  assign wr_en = write && chipselect;
  assign rd_en = read && chipselect;

  // Reprogramming the period or disabling the blinker restarts the phase from 0.
  assign restart = wr_en && ((address == ADDR_PERIOD) ||
                             ((address == ADDR_CTRL) && !writedata[CTRL_EN]));

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    en_d     = en_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = writedata[LED_W-1:0];
        ADDR_MASK:   mask_d   = writedata[LED_W-1:0];
        ADDR_PERIOD: period_d = writedata;
        ADDR_CTRL:   en_d     = writedata[CTRL_EN];
        default:     ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:   rd_word[LED_W-1:0] = data_q;
      ADDR_MASK:   rd_word[LED_W-1:0] = mask_q;
      ADDR_PERIOD: rd_word            = period_q;
      ADDR_CTRL: begin
        rd_word[CTRL_EN]    = en_q;
        rd_word[CTRL_PHASE] = phase;
      end
      default:     rd_word = '0;
    endcase
    rdata_d = rd_en ? rd_word : 32'd0;
  end

  always_comb begin
    led_d = '0;
    if (en_q) led_d = data_q & ~(mask_q & {LED_W{phase}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      mask_q   <= '0;
      period_q <= DEFAULT_PERIOD;
      en_q     <= 1'b1;
      rdata_q  <= '0;
      led_q    <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
      led_q    <= led_d;
    end
  end

  blink_timer u_blink_timer (
    .clk     (clk),
    .reset   (reset),
    .period  (period_q),
    .enable  (en_q),
    .restart (restart),
    .phase   (phase)
  );

  assign readdata = rdata_q;
  assign led      = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_writer.sv
// tb_led_writer: directed and random stimulus against a cycle-level reference model of led_writer.
`default_nettype none

module tb_led_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  led;

  int checks = 0;
  int passed = 0;

  // Reference model: phase is derived from the number of counting edges since the last restart.
  logic [9:0]  m_data, m_mask;
  logic [31:0] m_period;
  bit          m_en;
  int unsigned m_ticks;
  logic [31:0] e_rd;
  logic [9:0]  e_led;

  led_writer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .led        (led)
  );

  always #5 clk = ~clk;

  function automatic bit m_phase();
    if (m_period == 32'd0) return 1'b0;
    return ((m_ticks / m_period) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_data   = '0;
    m_mask   = '0;
    m_period = 32'd25000000;
    m_en     = 1'b1;
    m_ticks  = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic step(input bit c, input bit r, input bit w, input logic [1:0] a,
                      input logic [31:0] d);
    bit restart;
    chipselect = c; read = r; write = w; address = a; writedata = d;
    @(posedge clk);
    e_rd = 32'd0;
    if (c && r) begin
      case (a)
        2'd0: e_rd = {22'd0, m_data};
        2'd1: e_rd = {22'd0, m_mask};
        2'd2: e_rd = m_period;
        default: e_rd = {30'd0, m_phase(), m_en};
      endcase
    end
    e_led   = m_en ? (m_data & ~(m_mask & {10{m_phase()}})) : 10'd0;
    restart = c && w && (a == 2'd2 || (a == 2'd3 && !d[0]));
    if (restart) m_ticks = 0;
    else if (m_en && m_period != 32'd0) m_ticks++;
    if (c && w) begin
      case (a)
        2'd0: m_data = d[9:0];
        2'd1: m_mask = d[9:0];
        2'd2: m_period = d;
        default: m_en = d[0];
      endcase
    end
    #1;
    chk("led", {22'd0, led}, {22'd0, e_led});
    chk("readdata", readdata, e_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 2'd0; writedata = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", {22'd0, led}, 32'd0);
    chk("reset_rd", readdata, 32'd0);
    reset = 1'b0;

    // Reset values of all four registers.
    step(1, 1, 0, 2'd0, 0); chk("rst_data",   readdata, 32'd0);
    step(1, 1, 0, 2'd1, 0); chk("rst_mask",   readdata, 32'd0);
    step(1, 1, 0, 2'd2, 0); chk("rst_period", readdata, 32'd25000000);
    step(1, 1, 0, 2'd3, 0); chk("rst_ctrl",   readdata, 32'h1);

    // Write / read back and led latency.
    step(1, 0, 1, 2'd0, 32'h2AA);
    step(1, 1, 0, 2'd0, 0); chk("rd_2aa", readdata, 32'h2AA); chk("led_2aa", {22'd0, led}, 32'h2AA);
    step(1, 0, 1, 2'd0, 32'hFFFFFFFF);
    step(1, 1, 0, 2'd0, 0); chk("rd_trunc", readdata, 32'h3FF);

    // Blink with period 4.
    step(1, 0, 1, 2'd2, 32'd4);
    step(1, 0, 1, 2'd1, 32'h00F);
    step(1, 0, 1, 2'd0, 32'h3FF);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 2'd3, 0);
    idle(8);

    // Period 1, then 0, then rewrite mid-count.
    step(1, 0, 1, 2'd2, 32'd1);
    idle(6);
    step(1, 0, 1, 2'd2, 32'd0);
    idle(5);
    step(1, 1, 0, 2'd3, 0); chk("p0_phase", readdata, 32'h1); chk("p0_led", {22'd0, led}, 32'h3FF);
    step(1, 0, 1, 2'd2, 32'd3);
    idle(4);
    step(1, 0, 1, 2'd2, 32'd3);
    step(1, 1, 0, 2'd3, 0); chk("rewrite_phase", readdata, 32'h1);
    idle(5);

    // Enable off / on.
    step(1, 0, 1, 2'd3, 32'd0);
    step(1, 1, 0, 2'd3, 0); chk("en0_ctrl", readdata, 32'h0); chk("en0_led", {22'd0, led}, 32'h0);
    idle(4);
    step(1, 0, 1, 2'd3, 32'd1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 2'd3, 0);

    // Writes without chipselect are ignored.
    for (int a = 0; a < 4; a++) step(0, 1, 1, 2'(a), 32'h0);
    for (int a = 0; a < 4; a++) step(1, 1, 0, 2'(a), 0);

    // Same-cycle read and write.
    step(1, 0, 1, 2'd0, 32'h055);
    step(1, 1, 1, 2'd0, 32'h0AA); chk("rw_old", readdata, 32'h055);
    step(1, 1, 0, 2'd0, 0);       chk("rw_new", readdata, 32'h0AA);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2) d = $urandom_range(0, 6);
      if (a == 2'd3) d = {d[31:1], ($urandom_range(0, 4) != 0)};
      step($urandom_range(0, 7) != 0, 1'($urandom), ($urandom_range(0, 3) == 0), a, d);
    end

    // Async reset between edges while blinking.
    step(1, 0, 1, 2'd0, 32'h3FF);
    step(1, 0, 1, 2'd2, 32'd2);
    idle(3);
    step(1, 1, 0, 2'd2, 0);
    chk("pre_areset_rd", readdata, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_led", {22'd0, led}, 32'h0);
    chk("areset_rd", readdata, 32'h0);
    model_reset();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 0, 2'd2, 0); chk("post_rst_period", readdata, 32'd25000000);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_writer.md
Name: led_writer

Overview:
- Avalon-MM slave that drives LEDR0-9 from CPU writes. It is the write-side counterpart of the switch input peripheral and sits on the same lightweight bus.
- Holds an LED data register and a per-LED blink mask.
- A programmable half-period counter toggles a blink phase; masked LEDs flash while unmasked LEDs hold steady.
- Registers are read back with a 1-cycle registered latency.

Parameters:
- LED_W, 10, number of LED outputs (1..32).
- DEFAULT_PERIOD, 25000000, reset value of BLINK_PERIOD in clk cycles (0.5 s half-period at 50 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  2  register select
- chipselect  input  1  slave select; read/write are ignored when low
- read  input  1  read strobe
- write  input  1  write strobe
- writedata  input  32  write data
- readdata  output  32  registered read data
- led  output  LED_W  LED drive, 1 = on

Behaviour:
- Register map (a word outside a field reads 0, and writes to it are ignored):
  - 0 LED_DATA [LED_W-1:0], R/W, reset 0.
  - 1 BLINK_MASK [LED_W-1:0], R/W, reset 0.
  - 2 BLINK_PERIOD [31:0], R/W, reset DEFAULT_PERIOD.
  - 3 CTRL: bit0 EN (R/W, reset 1); bit1 PHASE (RO, reset 0).
- Write:
  - Occurs when write && chipselect. The register updates at that clk edge.
  - writedata bits above the field width are discarded.
- Read:
  - When read && chipselect, readdata <= selected register, zero-extended. The value is valid the cycle after the strobe.
  - In every other cycle readdata <= 0.
  - Reset value of readdata is 0.
- Simultaneous read and write to the same address in one cycle: readdata returns the pre-write value.
- Blink counter cnt[31:0]:
  - Reset value is 0.
  - If BLINK_PERIOD == 0: cnt holds 0 and PHASE holds 0, so blinking is disabled.
  - Else if cnt == BLINK_PERIOD-1: cnt <= 0 and PHASE <= ~PHASE.
  - Else cnt <= cnt+1.
  - BLINK_PERIOD == 1 therefore toggles PHASE every cycle.
- Any write to BLINK_PERIOD forces cnt <= 0 and PHASE <= 0 in the same edge. This takes priority over the wrap toggle.
- Any write to CTRL that clears EN also forces cnt <= 0 and PHASE <= 0. cnt keeps running while EN = 1 only.
- LED output (registered):
  - led <= EN ? (LED_DATA & ~(BLINK_MASK & {LED_W{PHASE}})) : 0.
  - It is computed from the register values at the current edge, so a write is visible on led 2 edges after the write strobe edge.
  - Reset value of led is 0.
- Reset asserted mid-operation: all registers, cnt, PHASE, led and readdata return to their reset values immediately, independent of clk.
  - After release, led shows 0 on the first edge, because LED_DATA = 0.
- write && read without chipselect: no effect, and readdata <= 0.

Decomposition:
- Shared package led_writer_pkg holds:
  - Address constants ADDR_DATA = 2'd0, ADDR_MASK = 2'd1, ADDR_PERIOD = 2'd2, ADDR_CTRL = 2'd3.
  - CTRL bit indices CTRL_EN = 0, CTRL_PHASE = 1.
- One natural sub-module, blink_timer:
  - Inputs: clk, reset, period[31:0], enable, restart.
  - Output: phase.
  - Contains cnt, the wrap compare and the phase toggle.
- The top level holds the register file, read mux and LED output register.

Test Plan:
- Reset check: assert reset for 3 cycles and read all 4 addresses. Expect readdata 0, 0, 25000000, 0x1; led = 0.
- Write and read back: write 0x2AA to address 0. The read on the next cycle returns 0x000002AA, and led = 0x2AA two edges after the write. Write 0xFFFFFFFF to address 0; read returns 0x3FF.
- Blink: write PERIOD = 4, MASK = 0x00F, DATA = 0x3FF.
  - led alternates 0x3FF for 4 cycles, then 0x3F0 for 4 cycles.
  - PHASE read at address 3 toggles between 0x1 and 0x3.
- Period edge cases:
  - PERIOD = 1: led toggles 0x3FF/0x3F0 every cycle.
  - PERIOD = 0: led is steady 0x3FF and PHASE stays 0.
  - Rewriting PERIOD mid-count: PHASE is 0 on the next read and the count restarts from 0.
- Enable and chipselect:
  - Write CTRL = 0: led = 0 after 2 edges and PHASE = 0.
  - Write CTRL = 1: blinking resumes from PHASE = 0.
  - A write with chipselect = 0 leaves all registers unchanged.
- Same-cycle read and write on address 0, old = 0x055, new = 0x0AA: readdata = 0x055, and a following read returns 0x0AA.
- Async reset mid-blink: asserting reset between edges forces led = 0 and readdata = 0 immediately.
